// File: rtl/slice_serial_adder_seq.sv
// slice_serial_adder_seq: sequences WIDTH-bit adds through an external SLICE-bit ripple-adder partition, LSB slice first.
module slice_serial_adder_seq #(
  parameter int WIDTH = 12,
  parameter int SLICE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);
  localparam int NS = WIDTH / SLICE;
  localparam int IW = NS > 1 ? $clog2(NS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [WIDTH-1:0] r_a, r_b, w_mask, w_ins;
  logic [31:0] w_off;
  logic r_carry, w_run, w_last;
  if (WIDTH <= 0 || SLICE <= 0 || WIDTH % SLICE != 0) begin : g_chk
    $error("WIDTH must be a positive multiple of SLICE");
  end
  assign w_run = r_state == RUN;
  assign w_last = r_idx == IW'(NS - 1);
  assign w_off = 32'(r_idx) * SLICE;
  assign w_mask = WIDTH'({SLICE{1'b1}}) << w_off;
  assign w_ins = WIDTH'(slice_sum) << w_off;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  // partition inputs are forced to 0 outside RUN so its output is never consumed stale
  assign slice_a = w_run ? SLICE'(r_a >> w_off) : '0;
  assign slice_b = w_run ? SLICE'(r_b >> w_off) : '0;
  assign slice_cin = w_run & r_carry;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = (in_ready && in_valid) ? RUN :
             (w_run && w_last) ? DONE :
             (out_valid && out_ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_carry <= 1'b0;
      r_idx <= '0;
      out_sum <= '0;
      out_cout <= 1'b0;
    end else if (in_ready && in_valid) begin
      r_a <= in_a;
      r_b <= in_b;
      r_carry <= in_cin;
      r_idx <= '0;
      out_sum <= '0;
    end else if (w_run) begin
      out_sum <= (out_sum & ~w_mask) | w_ins;
      r_carry <= slice_cout;
      r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) out_cout <= slice_cout;
    end
endmodule
